// File: rtl/ber_pkg.sv
// Shared constants and state encoding for the ber checker and its run controller.
// ADAPT_LEN covers the full ber shift search plus one strobe of margin.
package ber_pkg;

   localparam int BER_SEQ_LEN = 511;
   localparam int BER_REG_LEN = 64;
   localparam int BER_WIN_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ADAPT,
      ST_MEASURE,
      ST_HOLD
   } ber_state_e;

   function automatic int ber_adapt_len(input int seq_len);
      return seq_len * (seq_len + 1) + 1;
   endfunction

endpackage

// File: rtl/ber_strobe_cnt.sv
// Loadable strobe counter: load clears the count and latches a target; hit_o flags the
// strobe that brings the count to a nonzero target (combinational, same cycle). Saturates at all-ones.
module ber_strobe_cnt #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] tgt_i,
   input  logic         inc_i,
   output logic         hit_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] tgt_q, tgt_d;

   always_comb begin
      cnt_d = cnt_q;
      tgt_d = tgt_q;
      if (load_i) begin
         cnt_d = '0;
         tgt_d = tgt_i;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // A zero target never matches, which is what makes continuous mode run until abort.
   assign hit_o = inc_i && !load_i && (tgt_q != '0) && (cnt_q == (tgt_q - W'(1)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         tgt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         tgt_q <= tgt_d;
      end
   end

endmodule

// File: rtl/ber_ctrl.sv
// Sequences one BER run: clear, adapt (lock), measure window, snapshot counters.
// All outputs registered; start ignored while busy; done pulses 2 cycles after the terminal strobe.
module ber_ctrl
   import ber_pkg::*;
#(
   parameter int SEQ_LEN = BER_SEQ_LEN,
   parameter int REG_LEN = BER_REG_LEN,
   parameter int WIN_W   = BER_WIN_W
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [WIN_W-1:0]   win_len_i,
   input  logic               valid_i,
   input  logic [REG_LEN-1:0] ber_err_i,
   input  logic [REG_LEN-1:0] ber_bits_i,
   output logic               ber_rst_o,
   output logic               ber_enable_o,
   output logic               busy_o,
   output logic               locked_o,
   output logic               done_o,
   output logic               partial_o,
   output logic [REG_LEN-1:0] err_snap_o,
   output logic [REG_LEN-1:0] bits_snap_o
);

   localparam int                 ADAPT_LEN = ber_adapt_len(SEQ_LEN);
   localparam int                 ADAPT_W   = $clog2(ADAPT_LEN + 1);
   localparam logic [ADAPT_W-1:0] ADAPT_TGT = ADAPT_W'(ADAPT_LEN);

   ber_state_e         state_q;
   logic               ber_rst_q;
   logic               ber_en_q;
   logic               busy_q;
   logic               locked_q;
   logic               done_q;
   logic               partial_q;
   logic [REG_LEN-1:0] err_snap_q;
   logic [REG_LEN-1:0] bits_snap_q;

   logic run_accept;
   logic adapt_inc;
   logic win_inc;
   logic adapt_hit;
   logic win_hit;

   assign run_accept = (state_q == ST_IDLE) && start_i && !abort_i;
   assign adapt_inc  = valid_i && (state_q == ST_ADAPT);
   assign win_inc    = valid_i && (state_q == ST_MEASURE);

   ber_strobe_cnt #(.W(ADAPT_W)) u_adapt_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (run_accept),
      .tgt_i  (ADAPT_TGT),
      .inc_i  (adapt_inc),
      .hit_o  (adapt_hit)
   );

   // Loading on accept doubles as the win_len latch for the whole run.
   ber_strobe_cnt #(.W(WIN_W)) u_win_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (run_accept),
      .tgt_i  (win_len_i),
      .inc_i  (win_inc),
      .hit_o  (win_hit)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         ber_rst_q   <= 1'b1;
         ber_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         locked_q    <= 1'b0;
         done_q      <= 1'b0;
         partial_q   <= 1'b0;
         err_snap_q  <= '0;
         bits_snap_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (run_accept) begin
                  state_q   <= ST_CLEAR;
                  ber_rst_q <= 1'b0;
                  busy_q    <= 1'b1;
                  locked_q  <= 1'b0;
                  partial_q <= 1'b0;
               end
            end
            ST_CLEAR: begin
               ber_rst_q <= 1'b1;
               if (abort_i) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q  <= ST_ADAPT;
                  ber_en_q <= 1'b1;
               end
            end
            ST_ADAPT: begin
               if (abort_i) begin
                  state_q  <= ST_IDLE;
                  ber_en_q <= 1'b0;
                  busy_q   <= 1'b0;
                  locked_q <= 1'b0;
               end else if (adapt_hit) begin
                  state_q  <= ST_MEASURE;
                  locked_q <= 1'b1;
               end
            end
            ST_MEASURE: begin
               // A terminal strobe wins over a coincident abort: the window is complete.
               if (win_hit) begin
                  state_q  <= ST_HOLD;
                  ber_en_q <= 1'b0;
               end else if (abort_i) begin
                  state_q   <= ST_HOLD;
                  ber_en_q  <= 1'b0;
                  partial_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               err_snap_q  <= ber_err_i;
               bits_snap_q <= ber_bits_i;
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: begin
               state_q   <= ST_IDLE;
               ber_rst_q <= 1'b1;
               ber_en_q  <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign ber_rst_o    = ber_rst_q;
   assign ber_enable_o = ber_en_q;
   assign busy_o       = busy_q;
   assign locked_o     = locked_q;
   assign done_o       = done_q;
   assign partial_o    = partial_q;
   assign err_snap_o   = err_snap_q;
   assign bits_snap_o  = bits_snap_q;

endmodule

// File: tb/tb_ber_ctrl.sv
// Directed bench for ber_ctrl with SEQ_LEN=7 (ADAPT_LEN=57) and a small behavioural ber stand-in.
module tb_ber_ctrl;

   localparam int ADAPT = 7 * 8 + 1;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i, abort_i, valid_i, inj;
   logic [31:0] win_len_i;
   logic [63:0] ber_err_i, ber_bits_i;
   logic        ber_rst_o, ber_enable_o, busy_o, locked_o, done_o, partial_o;
   logic [63:0] err_snap_o, bits_snap_o;

   int n_cmp = 0;
   int n_bad = 0;

   ber_ctrl #(.SEQ_LEN(7), .REG_LEN(64), .WIN_W(32)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .win_len_i    (win_len_i),
      .valid_i      (valid_i),
      .ber_err_i    (ber_err_i),
      .ber_bits_i   (ber_bits_i),
      .ber_rst_o    (ber_rst_o),
      .ber_enable_o (ber_enable_o),
      .busy_o       (busy_o),
      .locked_o     (locked_o),
      .done_o       (done_o),
      .partial_o    (partial_o),
      .err_snap_o   (err_snap_o),
      .bits_snap_o  (bits_snap_o)
   );

   always #5 clk_i = ~clk_i;

   // ber stand-in: counts bits only after its shift search, i.e. from strobe ADAPT+1 on.
   int          m_str;
   logic [63:0] m_bits, m_err;
   always @(posedge clk_i) begin
      if (!rst_ni || !ber_rst_o) begin
         m_str  <= 0;
         m_bits <= '0;
         m_err  <= '0;
      end else if (ber_enable_o && valid_i) begin
         m_str <= m_str + 1;
         if (m_str + 1 > ADAPT) begin
            m_bits <= m_bits + 64'd1;
            if (inj) m_err <= m_err + 64'd1;
         end
      end
   end
   assign ber_err_i  = m_err;
   assign ber_bits_i = m_bits;

   typedef struct {
      int period;
      int win;
      int abort_at;
      bit abort_sv;
      int err1;
      int err2;
      int start_at;
      int exp_err;
      int exp_bits;
      bit exp_part;
   } run_t;

   run_t tab[8];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_case(input int idx, input run_t r, input bit chain);
      int  e, s, ms, lock_e, s57_e, term_e, done_e;
      bit  will, ab, st, in;
      e = 0; s = 0; lock_e = -1; s57_e = -2; term_e = -1; done_e = -1;
      start_i = 1'b1;
      win_len_i = r.win;
      tick();
      start_i = 1'b0;
      win_len_i = 32'd3;
      chk($sformatf("r%0d_clear_rst", idx), ber_rst_o, 1'b0);
      chk($sformatf("r%0d_clear_busy", idx), busy_o, 1'b1);
      chk($sformatf("r%0d_clear_partial", idx), partial_o, 1'b0);
      tick();
      chk($sformatf("r%0d_enable", idx), ber_enable_o, 1'b1);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         ms   = s - ADAPT;
         will = ((cyc % r.period) == 0) && (term_e < 0);
         ab   = 1'b0;
         if (r.abort_at > 0 && term_e < 0 && s >= ADAPT) begin
            if (r.abort_sv) ab = will && (ms + 1 == r.abort_at);
            else if (ms == r.abort_at) begin
               ab   = 1'b1;
               will = 1'b0;
            end
         end
         st = (r.start_at > 0) && (s >= ADAPT) && (ms == r.start_at) && (term_e < 0);
         in = will && (s >= ADAPT) && ((ms + 1 == r.err1) || (ms + 1 == r.err2));
         valid_i = will;
         abort_i = ab;
         start_i = st;
         inj     = in;
         tick();
         e++;
         if (will) begin
            s++;
            if (s == ADAPT) s57_e = e;
            if (r.win != 0 && s - ADAPT == r.win) term_e = e;
         end
         if (ab && term_e < 0) term_e = e;
         if (locked_o && lock_e < 0) lock_e = e;
         if (term_e == e) chk($sformatf("r%0d_hold_enable", idx), ber_enable_o, 1'b0);
         if (done_o) begin
            done_e = e;
            break;
         end
      end
      valid_i = 1'b0; abort_i = 1'b0; start_i = 1'b0; inj = 1'b0;
      chk($sformatf("r%0d_done_seen", idx), done_e >= 0, 1'b1);
      chk($sformatf("r%0d_lock_edge", idx), lock_e, s57_e);
      chk($sformatf("r%0d_done_edge", idx), done_e, term_e + 1);
      chk($sformatf("r%0d_err_snap", idx), err_snap_o, r.exp_err);
      chk($sformatf("r%0d_bits_snap", idx), bits_snap_o, r.exp_bits);
      chk($sformatf("r%0d_partial", idx), partial_o, r.exp_part);
      chk($sformatf("r%0d_busy_done", idx), busy_o, 1'b0);
      chk($sformatf("r%0d_locked_done", idx), locked_o, 1'b1);
      if (chain) begin
         start_i = 1'b1;
         win_len_i = 32'd9;
         tick();
         start_i = 1'b0;
         chk("chain_clear_rst", ber_rst_o, 1'b0);
         chk("chain_busy", busy_o, 1'b1);
         chk("chain_partial_cleared", partial_o, 1'b0);
         abort_i = 1'b1;
         tick();
         abort_i = 1'b0;
         chk("chain_abort_busy", busy_o, 1'b0);
         chk("chain_abort_rst", ber_rst_o, 1'b1);
      end else begin
         tick();
         chk($sformatf("r%0d_done_pulse", idx), done_o, 1'b0);
      end
   endtask

   initial begin
      bit saw_done;
      //          per win  ab  sv e1 e2 st  err bits part
      tab[0] = '{1, 100, 0,  0, 0, 0, 0,  0, 100, 0};
      tab[1] = '{3, 10,  0,  0, 3, 7, 0,  2, 10,  0};
      tab[2] = '{1, 0,   40, 0, 0, 0, 0,  0, 40,  1};
      tab[3] = '{2, 5,   0,  0, 1, 5, 0,  2, 5,   0};
      tab[4] = '{1, 20,  20, 1, 0, 0, 0,  0, 20,  0};
      tab[5] = '{1, 30,  0,  0, 0, 0, 10, 0, 30,  0};
      tab[6] = '{1, 1,   0,  0, 0, 0, 0,  0, 1,   0};
      tab[7] = '{1, 0,   15, 1, 0, 0, 0,  0, 15,  1};

      rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; valid_i = 1'b0;
      win_len_i = '0; inj = 1'b0;
      #12;
      chk("rst_ber_rst", ber_rst_o, 1'b1);
      chk("rst_enable", ber_enable_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_locked", locked_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_partial", partial_o, 1'b0);
      chk("rst_err_snap", err_snap_o, 64'd0);
      chk("rst_bits_snap", bits_snap_o, 64'd0);
      rst_ni = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) run_case(i, tab[i], 1'b0);

      // Abort on the 20th adapt strobe: no done, snapshots from the previous run survive.
      start_i = 1'b1; win_len_i = 32'd10;
      tick();
      start_i = 1'b0;
      tick();
      for (int i = 1; i <= 20; i++) begin
         valid_i = 1'b1;
         abort_i = (i == 20);
         tick();
      end
      valid_i = 1'b0; abort_i = 1'b0;
      chk("adapt_abort_busy", busy_o, 1'b0);
      chk("adapt_abort_enable", ber_enable_o, 1'b0);
      chk("adapt_abort_locked", locked_o, 1'b0);
      saw_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (done_o) saw_done = 1'b1;
         tick();
      end
      chk("adapt_abort_no_done", saw_done, 1'b0);
      chk("adapt_abort_bits_snap", bits_snap_o, 64'd15);
      chk("adapt_abort_err_snap", err_snap_o, 64'd0);
      chk("adapt_abort_partial", partial_o, 1'b0);

      // start and abort together in IDLE are refused.
      start_i = 1'b1; abort_i = 1'b1;
      tick();
      start_i = 1'b0; abort_i = 1'b0;
      chk("idle_sa_busy", busy_o, 1'b0);
      chk("idle_sa_ber_rst", ber_rst_o, 1'b1);

      // start in the done cycle is accepted.
      run_case(8, tab[7], 1'b1);

      // Asynchronous reset in MEASURE, then a normal run.
      start_i = 1'b1; win_len_i = 32'd50;
      tick();
      start_i = 1'b0;
      tick();
      valid_i = 1'b1;
      repeat (ADAPT + 10) tick();
      chk("pre_rst_enable", ber_enable_o, 1'b1);
      #2 rst_ni = 1'b0;
      #1;
      valid_i = 1'b0;
      chk("arst_enable", ber_enable_o, 1'b0);
      chk("arst_busy", busy_o, 1'b0);
      chk("arst_ber_rst", ber_rst_o, 1'b1);
      chk("arst_locked", locked_o, 1'b0);
      chk("arst_bits_snap", bits_snap_o, 64'd0);
      chk("arst_err_snap", err_snap_o, 64'd0);
      #2 rst_ni = 1'b1;
      tick();
      run_case(9, tab[1], 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ber_ctrl.md
# ber_ctrl

Run controller for the `ber` checker. It sequences one bit-error-rate measurement:
- clears the checker;
- enables it for the shift-search (adaptation) phase and declares lock after a fixed number of valid strobes;
- runs a measurement window of a programmable number of bits;
- snapshots the checker's error and bit counters into stable host-readable registers.

It sits between the host register file/GPIO and the `ber` instance in the DSP receive path.

## Interface
- `SEQ_LEN`, 511: PRBS length, must match the controlled `ber` instance.
- `REG_LEN`, 64: width of the `ber` counters and snapshots.
- `WIN_W`, 32: width of the window length.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle run request.
- `abort`  in  1  one-cycle stop request.
- `win_len`  in  WIN_W  measurement window in bits; 0 = continuous until abort; sampled on accepted start.
- `valid`  in  1  symbol strobe, the same signal that drives `ber.valid`.
- `ber_err`  in  REG_LEN  `ber.error_count`.
- `ber_bits`  in  REG_LEN  `ber.bit_count`.
- `ber_rst`  out  1  active-low synchronous clear to `ber.rst`; reset value 1.
- `ber_enable`  out  1  to `ber.enable`; reset value 0.
- `busy`  out  1  run in progress; reset 0.
- `locked`  out  1  adaptation complete for the current run; reset 0.
- `done`  out  1  one-cycle pulse, snapshots valid; reset 0.
- `partial`  out  1  last snapshot was ended by abort; reset 0.
- `err_snap`  out  REG_LEN  captured error count; reset 0.
- `bits_snap`  out  REG_LEN  captured bit count; reset 0.

## Operation
- ADAPT_LEN = SEQ_LEN*(SEQ_LEN+1)+1 valid strobes; this is the exact `ber` shift-search duration plus one strobe.
- States: IDLE, CLEAR, ADAPT, MEASURE, HOLD. All outputs are registered.
- IDLE:
  - `start` & !`abort` → CLEAR; latch `win_len`; `busy`=1; `locked`=0.
  - `start` & `abort` in the same cycle → remain in IDLE.
- CLEAR: exactly 1 cycle with `ber_rst`=0 and `ber_enable`=0, then → ADAPT.
- ADAPT:
  - `ber_enable`=1.
  - The adapt counter increments on `valid`.
  - When the strobe brings the count to ADAPT_LEN → MEASURE and `locked`=1.
- MEASURE:
  - The window counter increments on `valid`.
  - When the strobe brings the count to the latched `win_len` (nonzero) → HOLD. That strobe is still consumed by `ber`.
  - `ber_enable`=0 from HOLD onward.
- HOLD (1 cycle):
  - Load `err_snap`/`bits_snap` from `ber_err`/`ber_bits`.
  - Next cycle: `done`=1, `busy`=0, state IDLE.
- `abort` in CLEAR or ADAPT → IDLE. `ber_enable`=0, `locked`=0; no `done`; snapshots and `partial` unchanged.
- `abort` in MEASURE → HOLD with `partial`=1. This is the only exit from continuous mode.
- `abort` on the same cycle as the terminal strobe → normal completion, `partial`=0.
- `partial` is cleared on the next accepted start.
- `start` is ignored while `busy`. A `start` in the `done` cycle (state IDLE) is accepted.
- Counter widths:
  - Adapt counter is $clog2(ADAPT_LEN+1) bits.
  - Window counter is WIN_W bits; it cannot wrap because the terminal compare precedes the maximum.
  - In continuous mode the window counter saturates at all-ones; `ber_bits` remains the authoritative count.
- `rst` low in any state → immediate return of all outputs to reset values and state IDLE. The run is lost.

## Timing
- start (cycle 0) → CLEAR at cycle 1 (`ber_rst`=0).
- `ber_enable`=1 from cycle 2.
- `locked` rises 1 cycle after the ADAPT_LEN-th strobe.
- HOLD is 1 cycle after the terminal strobe. `done` and valid snapshots follow 1 cycle later, i.e. 2 cycles after the terminal strobe.
- Snapshots hold until the next HOLD or reset.

## Structure
- Package `ber_pkg`: state enum, default SEQ_LEN/REG_LEN, ADAPT_LEN function of SEQ_LEN. `ber` shares the same constants.
- One sub-module: `ber_strobe_cnt`, a loadable strobe counter with clear, count-on-valid and terminal-match flag. It is instantiated twice, for adapt and for window.

## Test plan
- SEQ_LEN=7 (ADAPT_LEN=57), `valid` every cycle, `win_len`=100, error-free `ber` → `locked` 1 cycle after strobe 57; `done` 2 cycles after strobe 157; `bits_snap`=100, `err_snap`=0, `partial`=0.
- `valid` every 3rd cycle, `win_len`=10, 2 injected `dx` errors in window → `err_snap`=2, `bits_snap`=10; `ber_enable` low from HOLD.
- `win_len`=0, abort after 40 measure strobes → `done` pulse, `partial`=1, `bits_snap`=40; next start clears `partial`.
- Abort at strobe 20 of ADAPT → IDLE, no `done`, `locked`=0, prior snapshots unchanged. Start+abort in IDLE → stays IDLE. Start during MEASURE → ignored.
- `rst` low mid-MEASURE → `ber_enable`=0, `busy`=0, snapshots 0, `ber_rst`=1 asynchronously. A new run after release completes normally.
- Start asserted in the `done` cycle → accepted; CLEAR pulse on the next cycle.
